// File: rtl/alu_pkg.sv
// Shared constants for the ALU command-issue slice: op encodings, FSM state
// encoding and command-word width helpers.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  function automatic int cmd_w(input int data_w, input int sel_w);
    return 2 * data_w + sel_w;
  endfunction

  localparam int CMD_W = cmd_w(2, 3);

endpackage

// File: rtl/alu_cmd_issue_if.sv
// Bundle of command, ALU-drive and result signals for alu_cmd_issue.
// res_parity exists only when ALU_RESULT_PARITY_EN is defined.
interface alu_cmd_issue_if #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 2,
  parameter int SEL_W  = 3,
  parameter int RES_W  = DATA_W + 1
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [DATA_W-1:0] cmd_a;
  logic [DATA_W-1:0] cmd_b;
  logic [SEL_W-1:0]  cmd_sel;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [SEL_W-1:0]  alu_sel;
  logic [RES_W-1:0]  alu_y;
  logic              res_valid;
  logic              res_ready;
  logic [RES_W-1:0]  res_data;
  logic [SEL_W-1:0]  res_sel;
  logic              busy;
  logic [CNT_W-1:0]  fifo_count;
`ifdef ALU_RESULT_PARITY_EN
  logic              res_parity;
`endif

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_sel, alu_y, res_ready,
    output cmd_ready, alu_a, alu_b, alu_sel, res_valid, res_data, res_sel,
           busy, fifo_count
`ifdef ALU_RESULT_PARITY_EN
    , output res_parity
`endif
  );

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_sel, alu_y, res_ready,
    input  cmd_ready, alu_a, alu_b, alu_sel, res_valid, res_data, res_sel,
           busy, fifo_count
`ifdef ALU_RESULT_PARITY_EN
    , input res_parity
`endif
  );

endinterface

// File: rtl/alu_cmd_fifo.sv
// Synchronous FIFO with occupancy count and async active-high reset.
// Head data is presented combinationally from the read pointer.
module alu_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 7
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CNT_FULL);
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rd_ptr];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  // Storage is not reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/alu_cmd_issue.sv
// Command-issue stage feeding a combinational 2-bit ALU: FIFO-buffered commands,
// registered operands, registered result handshake. Option: ALU_RESULT_PARITY_EN.
module alu_cmd_issue
  import alu_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 2,
  parameter int SEL_W  = 3,
  parameter int RES_W  = DATA_W + 1
) (
  input logic           clk,
  input logic           rst,
  alu_cmd_issue_if.slave bus
);
  localparam int CMD_BITS = cmd_w(DATA_W, SEL_W);
  localparam int CNT_W    = $clog2(DEPTH) + 1;

  logic [CMD_BITS-1:0] w_wdata;
  logic [CMD_BITS-1:0] w_head;
  logic                w_full;
  logic                w_empty;
  logic                w_pop;
  logic [CNT_W-1:0]    w_count;

  logic [1:0]          r_state;
  logic [DATA_W-1:0]   r_alu_a;
  logic [DATA_W-1:0]   r_alu_b;
  logic [SEL_W-1:0]    r_alu_sel;
  logic                r_res_valid;
  logic [RES_W-1:0]    r_res_data;
  logic [SEL_W-1:0]    r_res_sel;
`ifdef ALU_RESULT_PARITY_EN
  logic                r_res_parity;

  function automatic logic f_parity(input logic [RES_W-1:0] y);
    return ^y;
  endfunction
`endif

  assign w_wdata = {bus.cmd_a, bus.cmd_b, bus.cmd_sel};
  // Pop only in IDLE, or in HOLD once the held result is being accepted.
  assign w_pop   = !w_empty &&
                   ((r_state == S_IDLE) || ((r_state == S_HOLD) && bus.res_ready));

  alu_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CMD_BITS)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (bus.cmd_valid),
    .i_wdata (w_wdata),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_sel   <= '0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_sel   <= '0;
`ifdef ALU_RESULT_PARITY_EN
      r_res_parity <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            {r_alu_a, r_alu_b, r_alu_sel} <= w_head;
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_res_data  <= bus.alu_y;
          r_res_sel   <= r_alu_sel;
          r_res_valid <= 1'b1;
`ifdef ALU_RESULT_PARITY_EN
          r_res_parity <= f_parity(bus.alu_y);
`endif
          r_state     <= S_HOLD;
        end
        S_HOLD: begin
          if (bus.res_ready) begin
            r_res_valid <= 1'b0;
            if (w_pop) begin
              {r_alu_a, r_alu_b, r_alu_sel} <= w_head;
              r_state <= S_EXEC;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready  = !w_full;
  assign bus.alu_a      = r_alu_a;
  assign bus.alu_b      = r_alu_b;
  assign bus.alu_sel    = r_alu_sel;
  assign bus.res_valid  = r_res_valid;
  assign bus.res_data   = r_res_data;
  assign bus.res_sel    = r_res_sel;
  assign bus.busy       = (r_state != S_IDLE) || !w_empty;
  assign bus.fifo_count = w_count;
`ifdef ALU_RESULT_PARITY_EN
  assign bus.res_parity = r_res_parity;
`endif

endmodule

// File: tb/tb_alu_cmd_issue.sv
// Directed bench for alu_cmd_issue with a behavioural alu_2bit driving alu_y.
// Checks res_parity as well when ALU_RESULT_PARITY_EN is defined.
module tb_alu_cmd_issue;
  import alu_pkg::*;

  localparam int DEPTH  = 4;
  localparam int DATA_W = 2;
  localparam int SEL_W  = 3;
  localparam int RES_W  = 3;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  alu_cmd_issue_if #(.DEPTH(DEPTH), .DATA_W(DATA_W), .SEL_W(SEL_W), .RES_W(RES_W)) bus ();

  alu_cmd_issue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .SEL_W(SEL_W), .RES_W(RES_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] alu_model(input logic [1:0] a, input logic [1:0] b,
                                           input logic [2:0] sel);
    case (sel)
      OP_ADD:  return {1'b0, a} + {1'b0, b};
      OP_SUB:  return {1'b0, a} - {1'b0, b};
      OP_AND:  return {1'b0, a & b};
      OP_OR:   return {1'b0, a | b};
      OP_XOR:  return {1'b0, a ^ b};
      default: return 3'b000;
    endcase
  endfunction

  assign bus.alu_y = alu_model(bus.alu_a, bus.alu_b, bus.alu_sel);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] a, input logic [1:0] b, input logic [2:0] s);
    int n = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    bus.cmd_sel   = s;
    while (!bus.cmd_ready && n < 50) begin
      tick();
      n++;
    end
    if (!bus.cmd_ready) begin
      checks++; errors++;
      $display("FAIL push_timeout: cmd_ready=%0b required 1", bus.cmd_ready);
    end
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!bus.res_valid && n < 30) begin
      tick();
      n++;
    end
    if (!bus.res_valid) begin
      checks++; errors++;
      $display("FAIL %s_timeout: res_valid=%0b required 1", name, bus.res_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_a = '0; bus.cmd_b = '0; bus.cmd_sel = '0;
    bus.res_ready = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    checks++;
    if ({bus.res_valid, bus.res_data, bus.res_sel, bus.alu_a, bus.alu_b, bus.alu_sel,
         bus.fifo_count, bus.busy} !== 18'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h required 0", {bus.res_valid, bus.res_data,
               bus.res_sel, bus.alu_a, bus.alu_b, bus.alu_sel, bus.fifo_count, bus.busy});
    end
    checks++;
    if (bus.cmd_ready !== 1'b1) begin
      errors++; $display("FAIL reset_cmd_ready: got %b required 1", bus.cmd_ready);
    end
`ifdef ALU_RESULT_PARITY_EN
    checks++;
    if (bus.res_parity !== 1'b0) begin
      errors++; $display("FAIL reset_parity: got %b required 0", bus.res_parity);
    end
`endif
  endtask

  task automatic test_add();
    bus.res_ready = 1'b1;
    push(2'b01, 2'b10, 3'b000);
    checks++;
    if (bus.res_valid !== 1'b0) begin
      errors++; $display("FAIL add_lat0: res_valid=%b required 0", bus.res_valid);
    end
    tick();
    checks++;
    if ({bus.res_valid, bus.alu_a, bus.alu_b, bus.alu_sel} !== {1'b0, 2'b01, 2'b10, 3'b000}) begin
      errors++; $display("FAIL add_lat1: got %b required 00110000",
                         {bus.res_valid, bus.alu_a, bus.alu_b, bus.alu_sel});
    end
    tick();
    checks++;
    if ({bus.res_valid, bus.res_data, bus.res_sel} !== {1'b1, 3'b011, 3'b000}) begin
      errors++; $display("FAIL add_result: got %b required 1011000",
                         {bus.res_valid, bus.res_data, bus.res_sel});
    end
`ifdef ALU_RESULT_PARITY_EN
    checks++;
    if (bus.res_parity !== 1'b0) begin
      errors++; $display("FAIL add_parity: got %b required 0", bus.res_parity);
    end
`endif
    tick();
    checks++;
    if ({bus.res_valid, bus.busy} !== 2'b00) begin
      errors++; $display("FAIL add_drop: valid,busy=%b required 00", {bus.res_valid, bus.busy});
    end
  endtask

  task automatic test_sub_default();
    bus.res_ready = 1'b1;
    push(2'b11, 2'b01, 3'b001);
    push(2'b11, 2'b10, 3'b111);
    wait_valid("sub");
    checks++;
    if ({bus.res_data, bus.res_sel} !== {3'b010, 3'b001}) begin
      errors++; $display("FAIL sub_result: got %b required 010001", {bus.res_data, bus.res_sel});
    end
    tick();
    wait_valid("default_op");
    checks++;
    if ({bus.res_data, bus.res_sel} !== {alu_model(2'b11, 2'b10, 3'b111), 3'b111}) begin
      errors++; $display("FAIL default_op_result: got %b required %b",
                         {bus.res_data, bus.res_sel}, {alu_model(2'b11, 2'b10, 3'b111), 3'b111});
    end
    tick();
  endtask

  task automatic test_backpressure();
    bus.res_ready = 1'b0;
    push(2'b10, 2'b01, 3'b011);
    wait_valid("bp");
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({bus.res_valid, bus.res_data, bus.res_sel} !== {1'b1, 3'b011, 3'b011}) begin
        errors++; $display("FAIL bp_hold_%0d: got %b required 1011011", i,
                           {bus.res_valid, bus.res_data, bus.res_sel});
      end
      tick();
    end
    bus.res_ready = 1'b1;
    tick();
    checks++;
    if (bus.res_valid !== 1'b0) begin
      errors++; $display("FAIL bp_release: res_valid=%b required 0", bus.res_valid);
    end
  endtask

  task automatic test_fifo_full();
    logic [1:0] a   [5] = '{2'b11, 2'b01, 2'b11, 2'b11, 2'b10};
    logic [1:0] b   [5] = '{2'b10, 2'b10, 2'b10, 2'b11, 2'b11};
    logic [2:0] s   [5] = '{3'b010, 3'b011, 3'b100, 3'b000, 3'b001};
    logic [2:0] exp [5] = '{3'b010, 3'b011, 3'b001, 3'b110, 3'b111};
    bus.res_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(a[i], b[i], s[i]);
    checks++;
    if ({bus.fifo_count, bus.cmd_ready, bus.busy} !== {3'd4, 1'b0, 1'b1}) begin
      errors++; $display("FAIL full_state: count,ready,busy=%b required 10001",
                         {bus.fifo_count, bus.cmd_ready, bus.busy});
    end
    bus.cmd_valid = 1'b1; bus.cmd_a = 2'b00; bus.cmd_b = 2'b00; bus.cmd_sel = 3'b000;
    repeat (2) tick();
    checks++;
    if (bus.fifo_count !== 3'd4) begin
      errors++; $display("FAIL full_stall: fifo_count=%0d required 4", bus.fifo_count);
    end
    bus.cmd_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      wait_valid("full_drain");
      checks++;
      if ({bus.res_data, bus.res_sel} !== {exp[k], s[k]}) begin
        errors++; $display("FAIL full_order_%0d: got %b required %b", k,
                           {bus.res_data, bus.res_sel}, {exp[k], s[k]});
      end
`ifdef ALU_RESULT_PARITY_EN
      checks++;
      if (bus.res_parity !== ^exp[k]) begin
        errors++; $display("FAIL full_parity_%0d: got %b required %b", k, bus.res_parity, ^exp[k]);
      end
`endif
      bus.res_ready = 1'b1;
      tick();
    end
    repeat (3) tick();
    checks++;
    if ({bus.res_valid, bus.fifo_count, bus.busy} !== 5'b0) begin
      errors++; $display("FAIL full_empty: valid,count,busy=%b required 00000",
                         {bus.res_valid, bus.fifo_count, bus.busy});
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] a   [4] = '{2'b01, 2'b10, 2'b11, 2'b01};
    logic [1:0] b   [4] = '{2'b11, 2'b11, 2'b00, 2'b10};
    logic [2:0] s   [4] = '{3'b000, 3'b010, 3'b001, 3'b100};
    logic [2:0] exp [4] = '{3'b100, 3'b010, 3'b011, 3'b011};
    bus.res_ready = 1'b0;
    for (int i = 0; i < 3; i++) push(a[i], b[i], s[i]);
    checks++;
    if ({bus.fifo_count, bus.res_valid, bus.res_data} !== {3'd2, 1'b1, exp[0]}) begin
      errors++; $display("FAIL b2b_setup: got %b required %b",
                         {bus.fifo_count, bus.res_valid, bus.res_data}, {3'd2, 1'b1, exp[0]});
    end
    bus.res_ready = 1'b1;
    push(a[3], b[3], s[3]);
    checks++;
    if (bus.fifo_count !== 3'd2) begin
      errors++; $display("FAIL b2b_count: fifo_count=%0d required 2", bus.fifo_count);
    end
    for (int k = 1; k < 4; k++) begin
      wait_valid("b2b");
      checks++;
      if ({bus.res_data, bus.res_sel} !== {exp[k], s[k]}) begin
        errors++; $display("FAIL b2b_order_%0d: got %b required %b", k,
                           {bus.res_data, bus.res_sel}, {exp[k], s[k]});
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    bus.res_ready = 1'b0;
    push(2'b11, 2'b01, 3'b100);
    push(2'b10, 2'b10, 3'b011);
    push(2'b01, 2'b01, 3'b010);
    push(2'b10, 2'b01, 3'b000);
    bus.res_ready = 1'b1;
    push(2'b01, 2'b11, 3'b001);
    checks++;
    if ({bus.fifo_count, bus.res_valid, bus.alu_a, bus.res_data} !== {3'd3, 1'b0, 2'b10, 3'b010}) begin
      errors++; $display("FAIL rstmid_setup: got %b required 01101010",
                         {bus.fifo_count, bus.res_valid, bus.alu_a, bus.res_data});
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.res_valid, bus.res_data, bus.res_sel, bus.alu_a, bus.alu_b, bus.alu_sel,
         bus.fifo_count, bus.busy} !== 18'd0) begin
      errors++; $display("FAIL rstmid_async: got %h required 0", {bus.res_valid, bus.res_data,
               bus.res_sel, bus.alu_a, bus.alu_b, bus.alu_sel, bus.fifo_count, bus.busy});
    end
    repeat (2) tick();
    rst = 1'b0;
    push(2'b01, 2'b01, 3'b000);
    wait_valid("rstmid_after");
    checks++;
    if ({bus.res_data, bus.res_sel} !== {3'b010, 3'b000}) begin
      errors++; $display("FAIL rstmid_after: got %b required 010000", {bus.res_data, bus.res_sel});
    end
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_add();
    test_sub_default();
    test_backpressure();
    test_fifo_full();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_cmd_issue.md
Name: alu_cmd_issue

Overview:
Command-issue stage directly upstream of alu_2bit. It accepts {A, B, sel} commands over a valid/ready interface and buffers them in a small FIFO. It drives one command at a time onto the combinational ALU's operand and select inputs from registers, then captures the ALU's 3-bit result into a registered valid/ready output together with the op that produced it.

Parameters:
DEPTH, 4, command FIFO entries; power of 2, >= 2
DATA_W, 2, operand width; must equal alu_2bit A/B width
SEL_W, 3, op-select width; must equal alu_2bit sel width
RES_W, DATA_W+1, result width; must equal alu_2bit Y width

Ports:
clk  in  1  single clock, rising edge
rst  in  1  reset, asynchronous, active-high
cmd_valid  in  1  command offered
cmd_ready  out  1  FIFO can accept; = !full (combinational from registered count)
cmd_a  in  DATA_W  operand A
cmd_b  in  DATA_W  operand B
cmd_sel  in  SEL_W  op select (000 add, 001 sub, 010 and, 011 or, 100 xor, others default)
alu_a  out  DATA_W  registered operand to ALU A
alu_b  out  DATA_W  registered operand to ALU B
alu_sel  out  SEL_W  registered select to ALU sel
alu_y  in  RES_W  ALU combinational result Y
res_valid  out  1  result held
res_ready  in  1  downstream accepts result
res_data  out  RES_W  captured Y
res_sel  out  SEL_W  op that produced res_data
busy  out  1  FSM not in S_IDLE, or FIFO non-empty
fifo_count  out  $clog2(DEPTH)+1  entries currently in FIFO

Behaviour:
- Reset (asynchronous assert, any state): FIFO empty, pointers 0, fifo_count=0, FSM=S_IDLE; alu_a/alu_b/alu_sel=0, res_valid=0, res_data=0, res_sel=0, busy=0. Any in-flight command is discarded.
- Push: cmd_valid && cmd_ready at a rising edge writes the FIFO tail. A push when full is impossible because cmd_ready=0.
- Simultaneous push and pop: both are performed, and fifo_count is unchanged. A push into an empty FIFO is not visible to a pop in the same cycle.
- FSM transitions:
  - S_IDLE: if FIFO non-empty, pop the head into alu_a/alu_b/alu_sel and go to S_EXEC.
  - S_EXEC: capture alu_y into res_data and alu_sel into res_sel, set res_valid=1, go to S_HOLD.
  - S_HOLD: when res_ready=1, clear res_valid. If the FIFO is non-empty, pop the next command into the operand registers and go to S_EXEC; otherwise go to S_IDLE.
- res_valid, res_data and res_sel are stable while res_valid && !res_ready.
- Latency: the command accepted at edge N produces res_valid=1 after edge N+2.
- Throughput: one result per 2 cycles with res_ready held high.
- Operand registers hold their last value outside S_EXEC. They are not cleared after capture.
- The block does not decode sel. Values 101-111 pass through unchanged; the ALU returns 000 for them.
- Arithmetic is done entirely by the ALU. res_data is alu_y verbatim (add carries into bit 2; sub is 3-bit two's-complement, e.g. 01-10 = 111).
- FIFO pointers wrap modulo DEPTH. fifo_count ranges 0..DEPTH.

Optional Feature:
ALU_RESULT_PARITY_EN:
- Defined: adds output res_parity (1 bit) = XOR of the RES_W bits of captured alu_y. It is registered alongside res_data, resets to 0, and is held under backpressure.
- Undefined: the port and its logic are absent.

Decomposition:
- Package alu_pkg holds:
  - op localparams: OP_ADD=3'b000, OP_SUB=3'b001, OP_AND=3'b010, OP_OR=3'b011, OP_XOR=3'b100.
  - FSM state encoding: S_IDLE, S_EXEC, S_HOLD.
  - a command struct/concatenation width constant CMD_W = 2*DATA_W+SEL_W.
- One sub-module is natural: alu_cmd_fifo, a parameterised synchronous FIFO with async active-high reset and a count output. The FSM and result register live in the top.

Test Plan:
- Add: push A=01 B=10 sel=000, res_ready=1 -> res_valid after 2 cycles, res_data=011, res_sel=000.
- Sub and default op: push {11,01,001} then {11,10,111} -> res_data=010 then 000, in order. Check res_data=000 only via an alu_2bit model.
- Backpressure: push {10,01,011}, hold res_ready=0 for 5 cycles -> res_valid=1 with res_data=011 stable throughout; res_valid drops the cycle after res_ready=1.
- FIFO full: res_ready=0, push 5 commands back-to-back.
  - fifo_count reaches 4 (one command already in S_HOLD) and cmd_ready=0, so the last push stalls.
  - Release res_ready: all 5 results emerge in order (AND, OR, XOR mix, e.g. {11,10,100} -> 001).
- Reset mid-operation: assert rst while in S_EXEC with 3 entries queued.
  - All outputs are 0 immediately (asynchronous); fifo_count=0.
  - After release, a new {01,01,000} yields 010.
- Simultaneous push/pop: with FIFO at count 2, push while the FSM pops in S_HOLD -> fifo_count stays 2, ordering preserved.
- With ALU_RESULT_PARITY_EN defined: add 01+10 (Y=011) -> res_parity=0.
